// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access stage: FSM state, RV32I load/store funct3
// encodings, and the store byte-lane helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    function automatic logic [3:0] store_wmask(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        case (store_funct3_t'(funct3))
            SB:      return 4'b0001 << offset;
            SH:      return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [31:0] rs2,
                                                input logic [1:0]  offset);
        return rs2 << {offset, 3'b000};
    endfunction

    // Halfwords must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        return ((funct3[1:0] == 2'b01) && offset[0]) ||
               ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port between the memory-access stage (master) and the data
// memory (slave).
interface mem_access_unit_if;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of the
// returned word and sign- or zero-extends it according to funct3.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (load_funct3_t'(funct3))
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: drives the data-memory port for RV32I loads and stores and
// aligns load results. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        funct3_in,
    input  logic [31:0]       alu_out_in,
    input  logic [31:0]       rs2_in,
    input  logic              flush_in,
    mem_access_unit_if.master dmem,
    output logic [31:0]       load_data,
    output logic              mem_stall,
    output logic              memwb_load,
    output logic              misaligned
);
    mem_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  offset_q, offset_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        flushed_q, flushed_d;
    logic        trap_q, trap_d;
    logic        accept, trap_now, stall_c, load_c;

    assign accept = valid_in & (mem_read_in | mem_write_in);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_now = is_misaligned(funct3_in, alu_out_in[1:0]);
`else
    assign trap_now = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        offset_d  = offset_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        rdata_d   = rdata_q;
        read_d    = read_q;
        write_d   = write_q;
        flushed_d = flushed_q;
        trap_d    = trap_q;
        stall_c   = 1'b0;
        load_c    = 1'b0;

        case (state_q)
            IDLE: begin
                load_c = 1'b1;
                if (accept) begin
                    stall_c   = 1'b1;
                    load_c    = 1'b0;
                    addr_d    = {alu_out_in[31:2], 2'b00};
                    offset_d  = alu_out_in[1:0];
                    funct3_d  = funct3_in;
                    wdata_d   = store_wdata(rs2_in, alu_out_in[1:0]);
                    wmask_d   = mem_read_in ? 4'b0000 : store_wmask(funct3_in, alu_out_in[1:0]);
                    flushed_d = 1'b0;
                    if (trap_now) begin
                        trap_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // A load wins if both strobes arrive, keeping read and write exclusive.
                        read_d  = mem_read_in;
                        write_d = mem_write_in & ~mem_read_in;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_c   = 1'b1;
                flushed_d = flushed_q | flush_in;
                if (dmem.dmem_resp) begin
                    if (read_q) rdata_d = dmem.dmem_rdata;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                load_c    = ~(flushed_q | flush_in | trap_q);
                flushed_d = 1'b0;
                trap_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            offset_q  <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            rdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            flushed_q <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q   <= state_d;
            addr_q    <= addr_d;
            offset_q  <= offset_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            rdata_q   <= rdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            flushed_q <= flushed_d;
            trap_q    <= trap_d;
        end
    end

    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_wmask   = wmask_q;
    assign dmem.dmem_wdata   = wdata_q;

    // Reset must silence the latch enable at once, not only after the next edge.
    assign mem_stall  = stall_c & ~rst;
    assign memwb_load = load_c & ~rst;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = trap_q;
`else
    assign misaligned = 1'b0;
`endif

    load_align u_load_align (
        .rdata  (rdata_q),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// loads/stores checked against a byte-addressed memory model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read_in, mem_write_in, flush_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_out_in, rs2_in, load_data;
    logic        mem_stall, memwb_load, misaligned;

    mem_access_unit_if dmem();

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .funct3_in    (funct3_in),
        .alu_out_in   (alu_out_in),
        .rs2_in       (rs2_in),
        .flush_in     (flush_in),
        .dmem         (dmem),
        .load_data    (load_data),
        .mem_stall    (mem_stall),
        .memwb_load   (memwb_load),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference: byte memory for 0x100..0x13F; slave: word memory the bus writes into.
    logic [7:0]  ref_mem [0:63];
    logic [31:0] slv_mem [0:15];
    logic [2:0]  load_codes [0:4] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Lanes a store touches: the access bytes that fit in the word, or all four for sw.
    function automatic logic [3:0] lane_en(input logic [2:0] f3, input int off);
        logic [3:0] m;
        for (int k = 0; k < 4; k++)
            m[k] = (size_of(f3) == 4) || (k >= off && k < off + size_of(f3));
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] rs2, input int off);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 4; k++)
            if (k >= off) d[8*k +: 8] = rs2[8*(k-off) +: 8];
        return d;
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] rs2);
        int          wb;
        logic [3:0]  en;
        logic [31:0] d;
        wb = int'(addr - 32'h100) & ~3;
        en = lane_en(f3, int'(addr[1:0]));
        d  = lane_data(rs2, int'(addr[1:0]));
        for (int k = 0; k < 4; k++)
            if (en[k]) ref_mem[wb + k] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[4*widx + k];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int          size, base;
        logic [31:0] v;
        size = size_of(f3);
        base = int'(addr - 32'h100);
        if (size == 2) base = (base & ~3) + (addr[1] ? 2 : 0);
        if (size == 4) base = base & ~3;
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[base + i];
        if (!f3[2] && size < 4 && ref_mem[base + size - 1][7])
            for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic void poke_word(input logic [31:0] addr, input logic [31:0] val);
        int widx;
        widx = int'(addr - 32'h100) >> 2;
        slv_mem[widx] = val;
        for (int k = 0; k < 4; k++) ref_mem[4*widx + k] = val[8*k +: 8];
    endfunction

    task automatic idle_cycle(input logic resp);
        @(negedge clk);
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; flush_in = 1'b0;
        dmem.dmem_resp = resp; dmem.dmem_rdata = $urandom;
        #1;
        check("idle_stall", 32'(mem_stall), 0);
        check("idle_memwb", 32'(memwb_load), 1);
        check("idle_bus", 32'({dmem.dmem_read, dmem.dmem_write}), 0);
        check("idle_misaligned", 32'(misaligned), 0);
    endtask

    // One access: accept cycle, lat REQ cycles without resp, the resp cycle, then DONE.
    // flush_at < 0 means no flush; lat+1 flushes in DONE.
    task automatic access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int lat, input int flush_at);
        int          widx;
        logic [31:0] exp_load, exp_wdata;
        logic [3:0]  exp_wmask;
        widx      = int'(addr - 32'h100) >> 2;
        exp_wmask = lane_en(f3, int'(addr[1:0]));
        exp_wdata = lane_data(rs2, int'(addr[1:0]));
        exp_load  = '0;
        if (ld) exp_load = ref_load(f3, addr);
        else    ref_store(f3, addr, rs2);

        @(negedge clk);
        valid_in = 1'b1; mem_read_in = ld; mem_write_in = !ld; funct3_in = f3;
        alu_out_in = addr; rs2_in = rs2; flush_in = 1'b0;
        dmem.dmem_resp = 1'($urandom_range(1)); dmem.dmem_rdata = $urandom;
        #1;
        check("accept_stall", 32'(mem_stall), 1);
        check("accept_no_req", 32'({dmem.dmem_read, dmem.dmem_write}), 0);

        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            flush_in = (c == flush_at);
            dmem.dmem_resp = (c == lat);
            dmem.dmem_rdata = (c == lat) ? slv_mem[widx] : $urandom;
            #1;
            check("req_read", 32'(dmem.dmem_read), 32'(ld));
            check("req_write", 32'(dmem.dmem_write), 32'(!ld));
            check("req_addr", dmem.dmem_address, {addr[31:2], 2'b00});
            check("req_stall", 32'(mem_stall), 1);
            if (!ld) begin
                check("req_wmask", 32'(dmem.dmem_wmask), 32'(exp_wmask));
                check("req_wdata", dmem.dmem_wdata, exp_wdata);
                if (c == lat)
                    for (int k = 0; k < 4; k++)
                        if (dmem.dmem_wmask[k]) slv_mem[widx][8*k +: 8] = dmem.dmem_wdata[8*k +: 8];
            end
        end

        @(negedge clk);
        flush_in = (flush_at == lat + 1);
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = $urandom;
        #1;
        check("done_stall", 32'(mem_stall), 0);
        check("done_memwb", 32'(memwb_load), (flush_at >= 0) ? 0 : 1);
        check("done_bus", 32'({dmem.dmem_read, dmem.dmem_write}), 0);
        check("done_misaligned", 32'(misaligned), 0);
        if (ld) check("done_load_data", load_data, exp_load);
        else    check("done_mem_word", slv_mem[widx], ref_word(widx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_ld;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          r_lat, r_fl;

        rst = 1'b1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; flush_in = 1'b0;
        funct3_in = '0; alu_out_in = '0; rs2_in = '0;
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = '0;
        for (int i = 0; i < 16; i++) poke_word(32'h100 + 32'(4 * i), $urandom);

        #1;
        check("rst_read", 32'(dmem.dmem_read), 0);
        check("rst_write", 32'(dmem.dmem_write), 0);
        check("rst_wmask", 32'(dmem.dmem_wmask), 0);
        check("rst_address", dmem.dmem_address, 0);
        check("rst_wdata", dmem.dmem_wdata, 0);
        check("rst_load_data", load_data, 0);
        check("rst_misaligned", 32'(misaligned), 0);
        check("rst_memwb", 32'(memwb_load), 0);

        @(negedge clk);
        rst = 1'b0;
        idle_cycle(1'b0);

        // sw 0x100, response on the third REQ cycle
        access(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 2, -1);
        check("sw_wmask", 32'(dmem.dmem_wmask), 32'h0000000F);
        check("sw_wdata", dmem.dmem_wdata, 32'hDEADBEEF);
        check("sw_address", dmem.dmem_address, 32'h00000100);

        poke_word(32'h100, 32'h80FF0000);
        access(1'b1, 3'b000, 32'h103, 32'h0, 1, -1);
        check("lb_value", load_data, 32'hFFFFFF80);
        access(1'b1, 3'b100, 32'h103, 32'h0, 0, -1);
        check("lbu_value", load_data, 32'h00000080);

        access(1'b0, 3'b001, 32'h102, 32'h00001234, 1, -1);
        check("sh_wmask", 32'(dmem.dmem_wmask), 32'h0000000C);
        check("sh_wdata", dmem.dmem_wdata, 32'h12340000);

        // flush mid-REQ, then flush landing in DONE
        access(1'b1, 3'b010, 32'h108, 32'h0, 3, 1);
        access(1'b1, 3'b010, 32'h10C, 32'h0, 0, 1);

        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // reset while a load waits for its response
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        alu_out_in = 32'h104; dmem.dmem_resp = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_read_before", 32'(dmem.dmem_read), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_req_read", 32'(dmem.dmem_read), 0);
        check("rst_req_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_req_address", dmem.dmem_address, 0);
        check("rst_req_memwb", 32'(memwb_load), 0);
        @(negedge clk);
        valid_in = 1'b0; mem_read_in = 1'b0;
        rst = 1'b0;
        idle_cycle(1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010;
        alu_out_in = 32'h101; dmem.dmem_resp = 1'b0;
        #1;
        check("trap_accept_stall", 32'(mem_stall), 1);
        check("trap_accept_read", 32'(dmem.dmem_read), 0);
        @(negedge clk);
        #1;
        check("trap_misaligned", 32'(misaligned), 1);
        check("trap_memwb", 32'(memwb_load), 0);
        check("trap_read", 32'(dmem.dmem_read), 0);
        check("trap_stall", 32'(mem_stall), 0);
        idle_cycle(1'b0);
`endif

        for (int n = 0; n < 60; n++) begin
            r_ld   = 1'($urandom_range(1));
            r_f3   = r_ld ? load_codes[$urandom_range(4)] : 3'($urandom_range(2));
            r_addr = 32'h100 + 32'($urandom_range(63));
`ifdef MEM_MISALIGN_TRAP_EN
            if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
            if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
`endif
            r_lat = int'($urandom_range(3));
            r_fl  = ($urandom_range(3) == 0) ? int'($urandom_range(r_lat + 1)) : -1;
            access(r_ld, r_f3, r_addr, $urandom, r_lat, r_fl);
            if ($urandom_range(3) == 0) idle_cycle(1'($urandom_range(1)));
        end

        idle_cycle(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
